frv_masked_a2b: RTL and testbench

Iterative arithmetic-to-Boolean mask converter for the masked ALU. It takes a 32-bit secret x held as arithmetic shares (x = a0 + a1 mod 2^32) and returns Boolean shares (x = b0 ^ b1) using Goubin's carry-propagation method, with one fresh random word. It sits beside the masked bitwise unit and feeds Boolean-domain operands to it. The unmasked x is never formed in any register or net.

---
 rtl/frv_masked_a2b.sv | 179 +++++++++++++++++
 tb/tb_frv_masked_a2b.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/frv_masked_a2b.sv
// rtl/frv_masked_a2b.sv - iterative arithmetic-to-Boolean mask converter (Goubin carry propagation)
//
// Converts x held as arithmetic shares (x = i_a0 + i_a1 mod 2^N) into Boolean
// shares (x = o_b0 ^ o_b1) without ever forming x. One fresh random word
// (i_gamma) is consumed per conversion.
//
// Ports:
//   g_clk     in   clock, rising edge
//   g_resetn  in   synchronous active-low reset
//   ena       in   request, held high with stable inputs until rdy
//   i_a0      in   N  arithmetic share A
//   i_a1      in   N  arithmetic share r
//   i_gamma   in   N  fresh randomness, sampled once at capture
//   o_b0      out  N  Boolean share x ^ r
//   o_b1      out  N  Boolean share r
//   rdy       out  result valid (registered level, held while ena stays high)
//
// Configuration macro: FRV_MASKED_A2B_UNROLL2_EN
//   defined   - two chained iterations per LOOP cycle (single one at cnt=31)
//   undefined - one iteration per LOOP cycle

module frv_masked_a2b #(
    parameter int N = 32
) (
    input  logic         g_clk,
    input  logic         g_resetn,
    input  logic         ena,
    input  logic [N-1:0] i_a0,
    input  logic [N-1:0] i_a1,
    input  logic [N-1:0] i_gamma,
    output logic [N-1:0] o_b0,
    output logic [N-1:0] o_b1,
    output logic         rdy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOOP = 2'd1,
        S_FIN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t       state_q, state_d;
    logic [4:0]   cnt_q, cnt_d;
    logic         cap, step, fin;

    logic [N-1:0] t_q, xp_q, om_q, a_q, r_q;

    // One carry-propagation step: the masked carry word is rebuilt from the
    // shares and shifted up one place; the top carry falls off (mod 2^N).
    function automatic logic [N-1:0] a2b_step(
        input logic [N-1:0] t,
        input logic [N-1:0] r,
        input logic [N-1:0] a,
        input logic [N-1:0] om
    );
        logic [N-1:0] g;
        g = (t & r) ^ om ^ (t & a);
        return {g[N-2:0], 1'b0};
    endfunction

    // Init step, evaluated on the live inputs during the capture cycle.
    // Each intermediate stays masked by gamma or by a share.
    logic [N-1:0] t_init, xp_tmp, om_tmp, xp_init, g_tmp, om_init;

    always_comb begin
        t_init  = {i_gamma[N-2:0], 1'b0};
        xp_tmp  = i_gamma ^ i_a1;
        om_tmp  = i_gamma & xp_tmp;
        xp_init = t_init ^ i_a0;
        g_tmp   = (i_gamma ^ xp_init) & i_a1;
        om_init = om_tmp ^ g_tmp ^ (t_init & i_a0);
    end

    logic [N-1:0] t_step1, t_loop;
    logic [4:0]   cnt_inc;

    assign t_step1 = a2b_step(t_q, r_q, a_q, om_q);

`ifdef FRV_MASKED_A2B_UNROLL2_EN
    logic [N-1:0] t_step2;
    assign t_step2 = a2b_step(t_step1, r_q, a_q, om_q);
    // cnt visits 1,3,...,29 (two steps each) then 31 (one step): 31 in total.
    assign t_loop  = (cnt_q == 5'd31) ? t_step1 : t_step2;
    assign cnt_inc = 5'd2;
`else
    assign t_loop  = t_step1;
    assign cnt_inc = 5'd1;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap     = 1'b0;
        step    = 1'b0;
        fin     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ena) begin
                    cap     = 1'b1;
                    state_d = S_LOOP;
                    cnt_d   = 5'd1;
                end
            end
            S_LOOP: begin
                if (!ena) begin
                    state_d = S_IDLE;
                    cnt_d   = 5'd0;
                end else begin
                    step = 1'b1;
                    if (cnt_q == 5'd31) begin
                        state_d = S_FIN;
                        cnt_d   = 5'd0;
                    end else begin
                        cnt_d = cnt_q + cnt_inc;
                    end
                end
            end
            S_FIN: begin
                if (!ena) begin
                    state_d = S_IDLE;
                end else begin
                    fin     = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (!ena) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 5'd0;
            end
        endcase
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            rdy     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdy     <= (state_d == S_DONE);
        end
    end

    // Share registers only move when their state is active, so idle cycles
    // leave them untouched.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            t_q  <= '0;
            xp_q <= '0;
            om_q <= '0;
            a_q  <= '0;
            r_q  <= '0;
            o_b0 <= '0;
            o_b1 <= '0;
        end else begin
            if (cap) begin
                t_q  <= t_init;
                xp_q <= xp_init;
                om_q <= om_init;
                a_q  <= i_a0;
                r_q  <= i_a1;
            end else if (step) begin
                t_q <= t_loop;
            end
            if (fin) begin
                o_b0 <= xp_q ^ t_q;
                o_b1 <= r_q;
            end
        end
    end

endmodule

// File: tb/tb_frv_masked_a2b.sv
// tb/tb_frv_masked_a2b.sv - self-checking bench for frv_masked_a2b

module tb_frv_masked_a2b;

`ifdef FRV_MASKED_A2B_UNROLL2_EN
    localparam int LAT = 18;
`else
    localparam int LAT = 33;
`endif

    logic        clk;
    logic        g_resetn;
    logic        ena;
    logic [31:0] i_a0, i_a1, i_gamma;
    logic [31:0] o_b0, o_b1;
    logic        rdy;

    int checks = 0;
    int errors = 0;

    frv_masked_a2b #(.N(32)) dut (
        .g_clk    (clk),
        .g_resetn (g_resetn),
        .ena      (ena),
        .i_a0     (i_a0),
        .i_a1     (i_a1),
        .i_gamma  (i_gamma),
        .o_b0     (o_b0),
        .o_b1     (o_b1),
        .rdy      (rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] r;
        logic [31:0] g;
        logic [31:0] b0;
        logic [31:0] b1;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // Starts a request on the current negedge; inputs are scrambled after the
    // capture edge. lat counts edges from the capture edge up to the one after
    // which rdy is first seen high (-1 on timeout).
    task automatic run_req(input logic [31:0] a, input logic [31:0] r, input logic [31:0] g,
                           output logic [31:0] b0, output logic [31:0] b1, output int lat);
        i_a0 = a; i_a1 = r; i_gamma = g; ena = 1'b1;
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (k == 1) begin
                i_a0 = $urandom; i_a1 = $urandom; i_gamma = $urandom;
            end
            if (rdy) begin
                lat = k;
                break;
            end
        end
        b0 = o_b0;
        b1 = o_b1;
    endtask

    task automatic end_req();
        ena = 1'b0;
        @(negedge clk);
        check("rdy_fall", {31'd0, rdy}, 32'd0);
    endtask

    logic [31:0] b0, b1, hb0, hb1, ra, rr, rg;
    int lat;

    initial begin
        vecs[0] = '{32'h00000005, 32'h00000003, 32'h12345678, 32'h0000000B, 32'h00000003};
        vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h00000001, 32'h00000001};
        vecs[2] = '{32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 32'h00000001};
        vecs[3] = '{32'h80000000, 32'h80000000, 32'h5A5A5A5A, 32'h80000000, 32'h80000000};
        vecs[4] = '{32'h12345678, 32'h00000000, 32'hDEADBEEF, 32'h12345678, 32'h00000000};
        vecs[5] = '{32'h00000000, 32'hFFFFFFFF, 32'h0F0F0F0F, 32'h00000000, 32'hFFFFFFFF};
        vecs[6] = '{32'h7FFFFFFF, 32'h00000001, 32'hAAAAAAAA, 32'h80000001, 32'h00000001};
        vecs[7] = '{32'h00000001, 32'h0F0F0F0F, 32'h13579BDF, 32'h0000001F, 32'h0F0F0F0F};

        g_resetn = 1'b0; ena = 1'b0;
        i_a0 = 32'h0; i_a1 = 32'h0; i_gamma = 32'h0;
        repeat (3) @(negedge clk);
        check("reset_b0", o_b0, 32'h0);
        check("reset_b1", o_b1, 32'h0);
        check("reset_rdy", {31'd0, rdy}, 32'd0);
        g_resetn = 1'b1;
        @(negedge clk);
        check("idle_rdy", {31'd0, rdy}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            run_req(vecs[i].a, vecs[i].r, vecs[i].g, b0, b1, lat);
            check($sformatf("vec%0d_lat", i), lat, LAT);
            check($sformatf("vec%0d_b0", i), b0, vecs[i].b0);
            check($sformatf("vec%0d_b1", i), b1, vecs[i].b1);
            end_req();
        end

        // Hold after completion, then restart after one low cycle.
        run_req(vecs[0].a, vecs[0].r, vecs[0].g, hb0, hb1, lat);
        check("hold_lat", lat, LAT);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold_rdy", {31'd0, rdy}, 32'd1);
            check("hold_b0", o_b0, 32'h0000000B);
            check("hold_b1", o_b1, 32'h00000003);
        end
        end_req();
        run_req(vecs[1].a, vecs[1].r, vecs[1].g, b0, b1, lat);
        check("restart_lat", lat, LAT);
        check("restart_b0", b0, 32'h00000001);
        check("restart_b1", b1, 32'h00000001);
        end_req();

        // Abort: ena drops before edge E0+10; outputs keep the previous result.
        i_a0 = vecs[0].a; i_a1 = vecs[0].r; i_gamma = vecs[0].g; ena = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("abort_busy_rdy", {31'd0, rdy}, 32'd0);
        end
        ena = 1'b0;
        @(negedge clk);
        check("abort_rdy", {31'd0, rdy}, 32'd0);
        check("abort_b0", o_b0, 32'h00000001);
        check("abort_b1", o_b1, 32'h00000001);
        run_req(32'h80000000, 32'h80000000, 32'h31415926, b0, b1, lat);
        check("post_abort_lat", lat, LAT);
        check("post_abort_b0", b0, 32'h80000000);
        check("post_abort_b1", b1, 32'h80000000);
        end_req();

        // Reset at E0+5 of a running request.
        i_a0 = vecs[6].a; i_a1 = vecs[6].r; i_gamma = vecs[6].g; ena = 1'b1;
        repeat (5) @(negedge clk);
        g_resetn = 1'b0;
        @(negedge clk);
        check("midreset_b0", o_b0, 32'h0);
        check("midreset_b1", o_b1, 32'h0);
        check("midreset_rdy", {31'd0, rdy}, 32'd0);
        g_resetn = 1'b1; ena = 1'b0;
        @(negedge clk);
        check("midreset_idle_b0", o_b0, 32'h0);
        run_req(vecs[0].a, vecs[0].r, vecs[0].g, b0, b1, lat);
        check("after_reset_lat", lat, LAT);
        check("after_reset_b0", b0, 32'h0000000B);
        check("after_reset_b1", b1, 32'h00000003);
        end_req();

        // Random shares: Boolean shares must recombine to A + r.
        for (int i = 0; i < 200; i++) begin
            ra = $urandom; rr = $urandom; rg = $urandom;
            run_req(ra, rr, rg, b0, b1, lat);
            check("rand_lat", lat, LAT);
            check("rand_x", b0 ^ b1, ra + rr);
            check("rand_b1", b1, rr);
            end_req();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
